// File: rtl/filter_channel_scheduler.sv
// filter_channel_scheduler
// Shares one block filter engine among NUM_CH acquisition channels. Channel requests are
// round-robin arbitrated; each granted sample goes to the engine tagged with its channel and
// its first/last-of-block position. Engine results come back in order and are re-labelled
// with their channel from a small tag FIFO that holds one entry per outstanding block.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_enable, i_flush       run enable; counter/tag-FIFO clear (taken in idle only)
//   i_ch_valid, i_ch_data   per-channel sample requests and packed samples
//   o_ch_ack                one-hot pulse: sample of that channel consumed
//   o_eng_*, i_eng_ready    sample handshake to the engine with channel/first/last tags
//   i_res_valid, i_res_data engine result strobe and value
//   o_out_*                 registered result labelled with its channel
//   o_busy, o_err_overrun   activity flag; sticky result-without-tag error
module filter_channel_scheduler #(
   parameter int unsigned NUM_CH    = 16,
   parameter int unsigned BLOCK_LEN = 25,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned TAG_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic                        i_flush,
   input  logic [NUM_CH-1:0]           i_ch_valid,
   input  logic [NUM_CH*DATA_W-1:0]    i_ch_data,
   output logic [NUM_CH-1:0]           o_ch_ack,
   output logic                        o_eng_valid,
   input  logic                        i_eng_ready,
   output logic [DATA_W-1:0]           o_eng_data,
   output logic [$clog2(NUM_CH)-1:0]   o_eng_ch,
   output logic                        o_eng_first,
   output logic                        o_eng_last,
   input  logic                        i_res_valid,
   input  logic [DATA_W-1:0]           i_res_data,
   output logic                        o_out_valid,
   output logic [$clog2(NUM_CH)-1:0]   o_out_ch,
   output logic [DATA_W-1:0]           o_out_data,
   output logic                        o_busy,
   output logic                        o_err_overrun
);

   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned PW    = $clog2(TAG_DEPTH);
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {StIdle, StScan, StSend} state_t;

   state_t              r_state;
   logic [CH_W-1:0]     r_rr;
   logic [CH_W-1:0]     r_grant;
   logic [CNT_W-1:0]    r_cnt [NUM_CH];
   logic [DATA_W-1:0]   r_eng_data;
   logic [NUM_CH-1:0]   r_ch_ack;
   logic [CH_W-1:0]     r_tag [TAG_DEPTH];
   logic [PW-1:0]       r_wp;
   logic [PW-1:0]       r_rp;
   logic [PW:0]         r_fill;
   logic                r_out_valid;
   logic [CH_W-1:0]     r_out_ch;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_err;

   logic                w_send, w_first, w_last;
   logic                w_empty, w_full, w_pop, w_push;
   logic                w_eng_valid, w_hs, w_flush;
   logic                w_any;
   logic [CH_W-1:0]     w_gnt;
   logic [CH_W-1:0]     w_idx;
   logic [DATA_W-1:0]   w_gnt_data;

   assign w_send  = (r_state == StSend);
   assign w_first = w_send && (r_cnt[r_grant] == '0);
   assign w_last  = w_send && (r_cnt[r_grant] == CNT_W'(BLOCK_LEN - 1));
   assign w_empty = (r_fill == '0);
   assign w_full  = (r_fill == (PW + 1)'(TAG_DEPTH));
   assign w_pop   = i_res_valid && !w_empty;
   // A LAST needs a free tag slot; a pop in the same cycle frees one.
   assign w_eng_valid = w_send && !(w_last && w_full && !w_pop);
   assign w_hs    = w_eng_valid && i_eng_ready;
   assign w_push  = w_hs && w_last;
   assign w_flush = (r_state == StIdle) && i_flush;

   // First requesting channel at or after the round-robin pointer.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_idx = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_idx = r_rr + CH_W'(i);
         if (!w_any && i_ch_valid[w_idx]) begin
            w_any = 1'b1;
            w_gnt = w_idx;
         end
      end
   end

   always_comb begin
      w_gnt_data = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (CH_W'(k) == w_gnt) w_gnt_data = i_ch_data[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_rr       <= '0;
         r_grant    <= '0;
         r_eng_data <= '0;
         r_ch_ack   <= '0;
         for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      end else begin
         r_ch_ack <= '0;
         case (r_state)
            StIdle: begin
               if (i_flush) begin
                  for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
               end
               if (i_enable) r_state <= StScan;
            end
            StScan: begin
               if (!i_enable) begin
                  r_state <= StIdle;
               end else if (w_any) begin
                  r_grant    <= w_gnt;
                  r_eng_data <= w_gnt_data;
                  r_ch_ack   <= NUM_CH'(1) << w_gnt;
                  r_rr       <= w_gnt + 1'b1;
                  r_state    <= StSend;
               end
            end
            StSend: begin
               if (w_hs) begin
                  r_cnt[r_grant] <= w_last ? '0 : r_cnt[r_grant] + 1'b1;
                  r_state        <= i_enable ? StScan : StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Tag FIFO: channel of each completed block awaiting its result.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_fill <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) r_tag[i] <= '0;
      end else if (w_flush) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_fill <= '0;
      end else begin
         if (w_push) begin
            r_tag[r_wp] <= r_grant;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_out_valid <= w_pop;
         if (w_pop) begin
            r_out_ch   <= r_tag[r_rp];
            r_out_data <= i_res_data;
         end
         if (i_res_valid && w_empty) r_err <= 1'b1;
      end
   end

   assign o_ch_ack      = r_ch_ack;
   assign o_eng_valid   = w_eng_valid;
   assign o_eng_data    = r_eng_data;
   assign o_eng_ch      = r_grant;
   assign o_eng_first   = w_first;
   assign o_eng_last    = w_last;
   assign o_out_valid   = r_out_valid;
   assign o_out_ch      = r_out_ch;
   assign o_out_data    = r_out_data;
   assign o_busy        = (r_state != StIdle) || !w_empty;
   assign o_err_overrun = r_err;

endmodule

// File: doc/filter_channel_scheduler.md
Name: filter_channel_scheduler

Overview:
Shares one 25-sample median/mean filter engine among 16 acquisition channels. Each cycle it round-robin arbitrates the channels' sample requests and forwards one sample per handshake to the engine. It tags each sample with its channel, first-of-block and last-of-block flags. Engine results return in order and are re-labelled with their channel through an internal tag FIFO.

Parameters:
NUM_CH, 16, number of requesting channels (power of 2, 2..16)
BLOCK_LEN, 25, samples per channel per filter block (2..31)
DATA_W, 16, signed sample width
TAG_DEPTH, 4, tag FIFO depth (power of 2)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  scheduler run enable
FLUSH  in  1  one-cycle pulse; clears block counters and tag FIFO (honoured in IDLE only)
CH_VALID  in  NUM_CH  per-channel sample request
CH_DATA  in  NUM_CH*DATA_W  packed samples; channel k at bits [k*DATA_W +: DATA_W]
CH_ACK  out  NUM_CH  one-hot one-cycle pulse; sample of that channel consumed
ENG_VALID  out  1  sample valid to engine
ENG_READY  in  1  engine accepts sample
ENG_DATA  out  DATA_W  sample to engine
ENG_CH  out  log2(NUM_CH)  channel of ENG_DATA
ENG_FIRST  out  1  first sample of a channel block
ENG_LAST  out  1  last sample of a channel block
RES_VALID  in  1  engine result strobe (in order, one per LAST)
RES_DATA  in  DATA_W  engine result
OUT_VALID  out  1  registered result strobe
OUT_CH  out  log2(NUM_CH)  channel of OUT_DATA
OUT_DATA  out  DATA_W  result
BUSY  out  1  high whenever state != IDLE or tag FIFO non-empty
ERR_OVERRUN  out  1  sticky; RES_VALID arrived with tag FIFO empty

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, all block counters 0, tag FIFO empty.
- FSM states: IDLE, SCAN, SEND.
- IDLE: FLUSH=1 clears all counters and the tag FIFO. ENABLE=1 moves to SCAN on the next cycle.
- SCAN: ENABLE=0 returns to IDLE. Otherwise, if any CH_VALID is set, grant the first set channel at or after the RR pointer (wrapping). On that edge: capture CH_DATA of the granted channel into ENG_DATA, pulse CH_ACK[g] for exactly one cycle (coincident with the first SEND cycle), set RR pointer to g+1 mod NUM_CH, go to SEND. No CH_VALID set: stay in SCAN.
- SEND: ENG_FIRST = (cnt[g]==0), ENG_LAST = (cnt[g]==BLOCK_LEN-1).
  - ENG_VALID=1 unless ENG_LAST=1 and the tag FIFO is full; in that case ENG_VALID=0 and the block stalls until a tag pops.
  - ENG_DATA, ENG_CH, ENG_FIRST and ENG_LAST hold stable while ENG_VALID=1 && ENG_READY=0.
  - On handshake (ENG_VALID && ENG_READY): cnt[g] advances, wrapping BLOCK_LEN-1 -> 0. If LAST, push g to the tag FIFO. Next state is SCAN (if ENABLE=1) or IDLE (if ENABLE=0). ENABLE drop never aborts a pending SEND.
- Best-case throughput: one sample every 2 cycles (SCAN+SEND).
- Result path:
  - RES_VALID with FIFO non-empty: next cycle OUT_VALID=1, OUT_DATA=RES_DATA, OUT_CH=FIFO head, then pop.
  - RES_VALID with FIFO empty: OUT_VALID stays 0 and ERR_OVERRUN sets. It clears only on RESET.
  - Push and pop in the same cycle: both take effect. When the FIFO is full, simultaneous pop+push is legal and is not treated as a stall; the stall check uses full && !pop.
- Counters are per channel. Interleaved channels each keep their own block position.
- FLUSH outside IDLE is ignored.
- RESET asserted mid-SEND: the sample is dropped, ENG_VALID drops immediately (async), and all state returns to reset values.

Test Plan:
- Single channel 3: CH_VALID[3]=1 constant, data = 0..24, ENG_READY=1 -> 25 handshakes 2 cycles apart. ENG_CH=3, ENG_FIRST on data 0, ENG_LAST on data 24, 25 CH_ACK[3] pulses. Then RES_VALID with RES_DATA=12 -> OUT_VALID, OUT_CH=3, OUT_DATA=12.
- Fairness: CH_VALID=16'hFFFF constant -> grant order 0,1,...,15,0. No channel granted twice before all others are granted once.
- Backpressure: ENG_READY=0 for 10 cycles mid-block -> ENG_VALID stays 1, ENG_DATA/ENG_CH stable, no further CH_ACK. Release -> block counter advances by exactly 1.
- Tag FIFO full: 4 blocks completed with no RES_VALID, fifth LAST pending -> ENG_VALID=0, BUSY=1. One RES_VALID -> OUT_CH = first completed channel, the pending LAST then issues.
- Overrun and flush: RES_VALID with no outstanding LAST -> ERR_OVERRUN=1, stays 1. ENABLE=0, FLUSH pulse in IDLE -> next sample of any channel carries ENG_FIRST=1.
- Reset mid-SEND: assert RESET while ENG_VALID=1 -> all outputs 0 asynchronously, ERR_OVERRUN=0, RR pointer restarts at channel 0.
